pkt_to_gmii_tx: RTL and testbench

- Parametrised successor of the fixed 134b-to-GMII serialiser.
- Accepts tagged packet words of configurable width into an internal store-and-forward FIFO.
- Emits GMII byte stream: preamble/SFD, packet bytes MSB-first with no inter-word gaps, optional FCS, then a configurable inter-frame gap.
- Adds input backpressure, a complete-packet gate, malformed-word recovery and error counters; sits between the packet pipeline and the MAC/PHY pins.

---
 rtl/pkt_to_gmii_tx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pkt_to_gmii_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_to_gmii_tx.sv
// Store-and-forward packet-word to GMII serialiser with preamble/SFD, IFG, underrun abort and error counters.
// Define GMII_TX_FCS_EN to append a CRC-32 FCS (with zero padding to 60 bytes) to each frame.
module pkt_to_gmii_tx #(
    parameter int DATA_W       = 128,
    parameter int VLD_W        = $clog2(DATA_W/8),
    parameter int FIFO_DEPTH   = 512,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DATA_W+VLD_W+1:0]   in_data,
    output logic                      in_ready,
    output logic [7:0]                gmii_txd,
    output logic                      gmii_tx_en,
    output logic                      gmii_tx_er,
    output logic [31:0]               cnt_pkt,
    output logic [31:0]               cnt_drop,
    output logic [31:0]               cnt_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int IN_W  = DATA_W + VLD_W + 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [VLD_W-1:0] LAST_FULL = VLD_W'(BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_FCS, S_IFG, S_DISCARD} state_t;

    logic [IN_W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       pkt_cnt_q, pkt_cnt_d;
    logic              in_ready_q, in_ready_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d;
    logic              cur_tail_q, cur_tail_d;
    logic [VLD_W-1:0]  cur_last_q, cur_last_d;
    logic [VLD_W-1:0]  byte_idx_q, byte_idx_d;
    logic              starve_q, starve_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        txd_q, txd_d;
    logic              tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic [31:0]       cnt_pkt_q, cnt_pkt_d, cnt_drop_q, cnt_drop_d, cnt_err_q, cnt_err_d;
`ifdef GMII_TX_FCS_EN
    logic [31:0]       crc_q, crc_d;
    logic [5:0]        len_q, len_d;
    logic              pad_q, pad_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction
`endif

    logic              empty, full, wr_en, ovf, pop, malformed;
    logic [IN_W-1:0]   head;
    logic              head_tail, head_head;
    logic [VLD_W-1:0]  head_last;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en     = in_valid && in_ready_q;
    assign ovf       = in_valid && !in_ready_q;
    assign head      = mem[rd_ptr_q[AW-1:0]];
    assign head_tail = head[IN_W-1];
    assign head_head = head[IN_W-2];
    assign head_last = head_tail ? head[DATA_W +: VLD_W] : LAST_FULL;

    always_comb begin
        state_d    = state_q;
        cur_data_d = cur_data_q;
        cur_tail_d = cur_tail_q;
        cur_last_d = cur_last_q;
        byte_idx_d = byte_idx_q;
        starve_d   = starve_q;
        cnt_d      = cnt_q;
        cnt_pkt_d  = cnt_pkt_q;
        cnt_err_d  = cnt_err_q;
        txd_d      = '0;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        pop        = 1'b0;
        malformed  = 1'b0;
`ifdef GMII_TX_FCS_EN
        crc_d      = crc_q;
        len_d      = len_q;
        pad_d      = pad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty && (pkt_cnt_q != '0 || full)) begin
                    pop = 1'b1;
                    if (!head_head) begin
                        malformed = 1'b1;
                    end else begin
                        // The IDLE cycle already issues the first preamble byte, keeping the IFG exact.
                        cur_data_d = head[DATA_W-1:0];
                        cur_tail_d = head_tail;
                        cur_last_d = head_last;
                        state_d    = S_PREAMBLE;
                        cnt_d      = 16'd1;
                        cnt_pkt_d  = cnt_pkt_q + 32'd1;
                        txd_d      = 8'h55;
                        tx_en_d    = 1'b1;
`ifdef GMII_TX_FCS_EN
                        crc_d      = '1;
                        len_d      = '0;
`endif
                    end
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (cnt_q < 16'(PREAMBLE_LEN)) begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    txd_d      = 8'hD5;
                    byte_idx_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (starve_q) begin
                    tx_er_d   = 1'b1;
                    starve_d  = 1'b0;
                    cnt_err_d = cnt_err_q + 32'd1;
                    state_d   = S_DISCARD;
                end
`ifdef GMII_TX_FCS_EN
                else if (pad_q) begin
                    crc_d = crc32_byte(crc_q, 8'h00);
                    len_d = len_q + 6'd1;
                    if (len_q == 6'd59) begin
                        pad_d   = 1'b0;
                        state_d = S_FCS;
                        cnt_d   = '0;
                    end
                end
`endif
                else begin
                    txd_d      = cur_data_q[DATA_W-1 -: 8];
                    cur_data_d = cur_data_q << 8;
                    byte_idx_d = byte_idx_q + VLD_W'(1);
`ifdef GMII_TX_FCS_EN
                    crc_d = crc32_byte(crc_q, cur_data_q[DATA_W-1 -: 8]);
                    len_d = (len_q == 6'd60) ? len_q : len_q + 6'd1;
`endif
                    if (byte_idx_q == cur_last_q) begin
                        if (cur_tail_q) begin
`ifdef GMII_TX_FCS_EN
                            if (len_q < 6'd59) begin
                                pad_d = 1'b1;
                            end else begin
                                state_d = S_FCS;
                                cnt_d   = '0;
                            end
`else
                            state_d = S_IFG;
                            cnt_d   = '0;
`endif
                        end else if (!empty) begin
                            pop        = 1'b1;
                            cur_data_d = head[DATA_W-1:0];
                            cur_tail_d = head_tail;
                            cur_last_d = head_last;
                            byte_idx_d = '0;
                        end else begin
                            starve_d = 1'b1;
                        end
                    end
                end
            end
`ifdef GMII_TX_FCS_EN
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = ~crc_q[7:0];
                crc_d   = crc_q >> 8;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == 16'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
`endif
            S_IFG: begin
                if (cnt_q == 16'(IFG_LEN - 1)) state_d = S_IDLE;
                else                            cnt_d   = cnt_q + 16'd1;
            end
            S_DISCARD: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_tail) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        pkt_cnt_d  = pkt_cnt_q + (AW+1)'(wr_en && in_data[IN_W-1]) - (AW+1)'(pop && head_tail);
        cnt_drop_d = cnt_drop_q + 32'(ovf) + 32'(malformed);
        in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_IDLE;
            cur_data_q <= '0;
            cur_tail_q <= 1'b0;
            cur_last_q <= '0;
            byte_idx_q <= '0;
            starve_q   <= 1'b0;
            cnt_q      <= '0;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            cnt_pkt_q  <= '0;
            cnt_drop_q <= '0;
            cnt_err_q  <= '0;
`ifdef GMII_TX_FCS_EN
            crc_q      <= '1;
            len_q      <= '0;
            pad_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            cur_data_q <= cur_data_d;
            cur_tail_q <= cur_tail_d;
            cur_last_q <= cur_last_d;
            byte_idx_q <= byte_idx_d;
            starve_q   <= starve_d;
            cnt_q      <= cnt_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            cnt_pkt_q  <= cnt_pkt_d;
            cnt_drop_q <= cnt_drop_d;
            cnt_err_q  <= cnt_err_d;
`ifdef GMII_TX_FCS_EN
            crc_q      <= crc_d;
            len_q      <= len_d;
            pad_q      <= pad_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign cnt_pkt    = cnt_pkt_q;
    assign cnt_drop   = cnt_drop_q;
    assign cnt_err    = cnt_err_q;
endmodule

// File: tb/tb_pkt_to_gmii_tx.sv
// Directed bench for pkt_to_gmii_tx: frame capture on the GMII side compared against hand-built frames.
module tb_pkt_to_gmii_tx;
    localparam int DATA_W     = 128;
    localparam int VLD_W      = $clog2(DATA_W/8);
    localparam int IN_W       = DATA_W + VLD_W + 2;
    localparam int BYTES      = DATA_W / 8;
    localparam int FIFO_DEPTH = 512;

    logic            clk, rst_n, in_valid, in_ready;
    logic [IN_W-1:0] in_data;
    logic [7:0]      gmii_txd;
    logic            gmii_tx_en, gmii_tx_er;
    logic [31:0]     cnt_pkt, cnt_drop, cnt_err;

    pkt_to_gmii_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .PREAMBLE_LEN(7), .IFG_LEN(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .cnt_pkt(cnt_pkt), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
    );

    typedef struct {
        int unsigned off;
        int unsigned len;
        int unsigned start_cyc;
        int unsigned end_cyc;
        int unsigned er;
    } frame_t;

    frame_t      frames[$];
    frame_t      cur;
    logic [7:0]  fbytes[$];
    logic [7:0]  exp_pay[$];
    logic        in_frame;
    int unsigned cyc, er_total, idle_bad;
    int unsigned n_checks, n_errors;
    int unsigned exp_pkt, exp_drop, exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        in_frame = 1'b0; er_total = 0; idle_bad = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else if (gmii_tx_en) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur.off = fbytes.size(); cur.len = 0; cur.start_cyc = cyc; cur.er = 0;
                end
                fbytes.push_back(gmii_txd);
                cur.len++;
                cur.end_cyc = cyc;
                if (gmii_tx_er) begin
                    cur.er++;
                    er_total++;
                end
            end else begin
                if (gmii_tx_er || gmii_txd != 8'h00) idle_bad++;
                if (in_frame) begin
                    frames.push_back(cur);
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [IN_W-1:0] mkw(input logic [1:0] tag, input int unsigned vld, input int unsigned seed);
        logic [IN_W-1:0] w;
        w = '0;
        w[IN_W-1 -: 2] = tag;
        w[DATA_W +: VLD_W] = VLD_W'(vld);
        for (int unsigned j = 0; j < BYTES; j++) w[DATA_W-1-8*j -: 8] = 8'(seed + j);
        return w;
    endfunction

    task automatic exp_add(input int unsigned seed, input int unsigned n);
        for (int unsigned j = 0; j < n; j++) exp_pay.push_back(8'(seed + j));
    endtask

    task automatic put(input logic [IN_W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k;
        k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, frames.size(), n);
    endtask

    task automatic check_frame(input int unsigned idx, input string tag);
        logic [7:0]  want[$];
        int unsigned nbad, n;
        want = {};
        repeat (7) want.push_back(8'h55);
        want.push_back(8'hD5);
        foreach (exp_pay[i]) want.push_back(exp_pay[i]);
`ifdef GMII_TX_FCS_EN
        begin
            logic [31:0] crc;
            logic [7:0]  b;
            crc = '1;
            n = exp_pay.size();
            for (int unsigned i = 0; i < ((n < 60) ? 60 : n); i++) begin
                b = (i < n) ? exp_pay[i] : 8'h00;
                if (i >= n) want.push_back(8'h00);
                crc = crc ^ {24'd0, b};
                for (int unsigned k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
            end
            crc = ~crc;
            for (int unsigned k = 0; k < 4; k++) want.push_back(crc[8*k +: 8]);
        end
`endif
        if (idx >= frames.size()) begin
            check({tag, "_present"}, frames.size(), idx + 1);
            return;
        end
        check({tag, "_len"}, frames[idx].len, want.size());
        n = (frames[idx].len < want.size()) ? frames[idx].len : want.size();
        nbad = 0;
        for (int unsigned i = 0; i < n; i++)
            if (fbytes[frames[idx].off + i] !== want[i]) nbad++;
        check({tag, "_bad_bytes"}, nbad, 0);
        check({tag, "_tx_er"}, frames[idx].er, 0);
    endtask

    initial begin
        int unsigned base, k, nbad, n;
        logic [7:0]  wb;
        n_checks = 0; n_errors = 0;
        exp_pkt = 0; exp_drop = 0; exp_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_tx_en", gmii_tx_en, 1'b0);
        check("rst_tx_er", gmii_tx_er, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_cnt_pkt", cnt_pkt, 0);
        check("rst_cnt_drop", cnt_drop, 0);
        check("rst_cnt_err", cnt_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // single head+tail word, 4 bytes
        exp_pay = {}; exp_add(1, 4);
        put(mkw(2'b11, 3, 1)); exp_pkt++;
        wait_frames(1, 300, "t1_wait");
        check_frame(0, "t1");
        check("t1_cnt_pkt", cnt_pkt, exp_pkt);
        wait_cycles(20);

        // three-word packet followed by a 2-byte packet: gap-free data and exact IFG
        base = frames.size();
        put(mkw(2'b01, 0, 8'h10));
        put(mkw(2'b00, 0, 8'h20));
        put(mkw(2'b10, 0, 8'h30));
        put(mkw(2'b11, 1, 8'h40));
        exp_pkt += 2;
        wait_frames(base + 2, 600, "t2_wait");
        exp_pay = {}; exp_add(8'h10, 16); exp_add(8'h20, 16); exp_add(8'h30, 1);
        check_frame(base, "t2_long");
        exp_pay = {}; exp_add(8'h40, 2);
        check_frame(base + 1, "t2_next");
        if (frames.size() >= base + 2)
            check("t2_gap", frames[base+1].start_cyc - frames[base].end_cyc, 13);
        check("t2_cnt_pkt", cnt_pkt, exp_pkt);
        wait_cycles(20);

        // headless word at FIFO head is discarded, then a normal packet follows
        base = frames.size();
        put(mkw(2'b00, 0, 8'h50)); exp_drop++;
        put(mkw(2'b11, 15, 8'h60)); exp_pkt++;
        wait_frames(base + 1, 400, "t3_wait");
        exp_pay = {}; exp_add(8'h60, 16);
        check_frame(base, "t3");
        wait_cycles(40);
        check("t3_frames", frames.size(), base + 1);
        check("t3_cnt_drop", cnt_drop, exp_drop);
        check("t3_cnt_pkt", cnt_pkt, exp_pkt);

        // back-to-back single-word packets: simultaneous tail write and tail read
        base = frames.size();
        for (int unsigned p = 0; p < 4; p++) put(mkw(2'b11, p, 8'h80 + 16*p));
        exp_pkt += 4;
        wait_frames(base + 4, 1000, "t4_wait");
        for (int unsigned p = 0; p < 4; p++) begin
            exp_pay = {}; exp_add(8'h80 + 16*p, p + 1);
            check_frame(base + p, $sformatf("t4_f%0d", p));
            if (p > 0 && frames.size() > base + p)
                check($sformatf("t4_gap%0d", p), frames[base+p].start_cyc - frames[base+p-1].end_cyc, 13);
        end
        check("t4_cnt_pkt", cnt_pkt, exp_pkt);
        wait_cycles(30);

        // fill FIFO with an unterminated packet: overflow, cut-through, underrun, discard
        base = frames.size();
        for (int unsigned w = 0; w < FIFO_DEPTH; w++) put(mkw((w == 0) ? 2'b01 : 2'b00, 0, w));
        check("t5_full_in_ready", in_ready, 1'b0);
        put(mkw(2'b00, 0, 8'hEE)); exp_drop++; exp_pkt++;
        check("t5_drained_in_ready", in_ready, 1'b1);
        k = 0;
        while (er_total < 1 && k < 10000) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_underrun_seen", er_total, 1);
        exp_err++;
        put(mkw(2'b00, 0, 8'hD0));
        put(mkw(2'b00, 0, 8'hD1));
        put(mkw(2'b10, 5, 8'hD2));
        wait_frames(base + 1, 100, "t5_wait");
        wait_cycles(50);
        check("t5_frames", frames.size(), base + 1);
        if (frames.size() > base) begin
            check("t5_len", frames[base].len, 8 + FIFO_DEPTH*BYTES + 1);
            check("t5_er_count", frames[base].er, 1);
            n = (frames[base].len < 8 + FIFO_DEPTH*BYTES + 1) ? frames[base].len : 8 + FIFO_DEPTH*BYTES + 1;
            nbad = 0;
            for (int unsigned i = 0; i < n; i++) begin
                if (i < 7)                         wb = 8'h55;
                else if (i == 7)                   wb = 8'hD5;
                else if (i < 8 + FIFO_DEPTH*BYTES) wb = 8'((i - 8) / BYTES + (i - 8) % BYTES);
                else                               wb = 8'h00;
                if (fbytes[frames[base].off + i] !== wb) nbad++;
            end
            check("t5_bad_bytes", nbad, 0);
        end
        check("t5_cnt_err", cnt_err, exp_err);
        check("t5_cnt_drop", cnt_drop, exp_drop);
        check("t5_cnt_pkt", cnt_pkt, exp_pkt);
        base = frames.size();
        put(mkw(2'b11, 2, 8'h90)); exp_pkt++;
        wait_frames(base + 1, 300, "t5_recover_wait");
        exp_pay = {}; exp_add(8'h90, 3);
        check_frame(base, "t5_recover");
        wait_cycles(30);

        // asynchronous reset in the middle of the data phase, with a second packet queued
        base = frames.size();
        put(mkw(2'b11, 15, 8'hA0));
        put(mkw(2'b11, 15, 8'hB0));
        k = 0;
        while (!(in_frame && cur.len >= 13) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("t6_sync", (in_frame && cur.len >= 13), 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_tx_en", gmii_tx_en, 1'b0);
        check("t6_txd", gmii_txd, 8'h00);
        check("t6_tx_er", gmii_tx_er, 1'b0);
        check("t6_cnt_pkt", cnt_pkt, 0);
        check("t6_cnt_drop", cnt_drop, 0);
        check("t6_cnt_err", cnt_err, 0);
        exp_pkt = 0; exp_drop = 0; exp_err = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        put(mkw(2'b11, 5, 8'hC0)); exp_pkt++;
        wait_frames(base + 1, 300, "t6_wait");
        exp_pay = {}; exp_add(8'hC0, 6);
        check_frame(base, "t6_after");
        wait_cycles(60);
        check("t6_no_residue", frames.size(), base + 1);
        check("t6_cnt_pkt_after", cnt_pkt, exp_pkt);

        check("idle_lines_quiet", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
